alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_core.sv | 70 +++++++
 rtl/alu.sv | 72 +++++++
 tb/tb_alu.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: the opcode encoding and the flag bit positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: alu_op_e (ALU_ADD/ALU_SUB/ALU_AND/ALU_SHL), FLAG_C, FLAG_Z, NUM_FLAGS.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_SHL = 2'b11
    } alu_op_e;

    // Bit positions inside ALUFlags.
    localparam int FLAG_C    = 0;
    localparam int FLAG_Z    = 1;
    localparam int NUM_FLAGS = 2;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// Combinational ALU datapath: ADD / SUB / AND / SHL on unsigned WIDTH-bit operands.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the result follows the inputs.
// Ports: a, b (operands; b is the shift amount for SHL), op (opcode) ->
//        result (WIDTH bits), c_flag (carry / borrow / shifted-out bit), z_flag (result == 0).
// Build option: ALU_SHIFT_CARRY_EN makes SHL report the last bit shifted out of a in c_flag;
//               without it SHL always reports c_flag = 0.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] result,
    output logic             c_flag,
    output logic             z_flag
);

    // One extra bit on top catches the carry-out of ADD and the borrow of SUB:
    // for SUB the top bit is set exactly when the subtraction wraps, i.e. a < b.
    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] diff_ext;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

`ifdef ALU_SHIFT_CARRY_EN
    // Shifting a one-bit-wider copy leaves a[WIDTH-b] in the top bit for 1 <= b <= WIDTH;
    // b == 0 and b > WIDTH both leave it 0, which is the required carry in those cases.
    logic [WIDTH:0] shl_ext;
    assign shl_ext = {1'b0, a} << b;
`endif

    always_comb begin
        result = '0;
        c_flag = 1'b0;
        unique case (op)
            ALU_ADD: begin
                result = sum_ext[WIDTH-1:0];
                c_flag = sum_ext[WIDTH];
            end
            ALU_SUB: begin
                result = diff_ext[WIDTH-1:0];
                c_flag = diff_ext[WIDTH];
            end
            ALU_AND: begin
                result = a & b;
                c_flag = 1'b0;
            end
            ALU_SHL: begin
                // A shift by b >= WIDTH moves every bit out, giving 0.
                result = a << b;
`ifdef ALU_SHIFT_CARRY_EN
                c_flag = shl_ext[WIDTH];
`else
                c_flag = 1'b0;
`endif
            end
            default: begin
                result = '0;
                c_flag = 1'b0;
            end
        endcase
    end

    assign z_flag = (result == '0);

endmodule : alu_core

// File: rtl/alu.sv
// Registered ALU: alu_core datapath followed by result/flag/valid output registers.
// Latency: 1 cycle from in_valid to out_valid; one result per cycle, no bubbles.
// Backpressure: none; no stall input, outputs hold their last value while in_valid is low.
// Ports: clk, rst_n (async active-low), in_valid, A, B, ALUControl (opcode) ->
//        ALUResult, ALUFlags (bit0 = C, bit1 = Z), out_valid.
// Build option: ALU_SHIFT_CARRY_EN (see alu_core) selects the SHL carry behaviour.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [1:0]           ALUControl,
    output logic [WIDTH-1:0]     ALUResult,
    output logic [NUM_FLAGS-1:0] ALUFlags,
    output logic                 out_valid
);

    logic [WIDTH-1:0]     core_result;
    logic                 core_c;
    logic                 core_z;

    logic [WIDTH-1:0]     result_d, result_q;
    logic [NUM_FLAGS-1:0] flags_d,  flags_q;
    logic                 valid_d,  valid_q;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (A),
        .b      (B),
        .op     (alu_op_e'(ALUControl)),
        .result (core_result),
        .c_flag (core_c),
        .z_flag (core_z)
    );

    // Load on in_valid; otherwise keep the last result visible and drop out_valid.
    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        valid_d  = 1'b0;
        if (in_valid) begin
            result_d         = core_result;
            flags_d[FLAG_C]  = core_c;
            flags_d[FLAG_Z]  = core_z;
            valid_d          = 1'b1;
        end
    end

    // Anything presented while rst_n is low is discarded by the asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
            valid_q  <= valid_d;
        end
    end

    assign ALUResult = result_q;
    assign ALUFlags  = flags_q;
    assign out_valid = valid_q;

endmodule : alu

// File: tb/tb_alu.sv
// Self-checking bench for alu (WIDTH = 4): directed vectors, a hold cycle, mid-stream reset,
// back-to-back traffic and a short random run, checked through an expected-result queue.
module tb_alu;
    import alu_pkg::*;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic [W-1:0]   a_in = '0;
    logic [W-1:0]   b_in = '0;
    logic [1:0]     ctl = 2'b00;
    logic [W-1:0]   alu_result;
    logic [1:0]     alu_flags;
    logic           out_valid;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         z;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp = '0;
    int   n_vec = 0;
    int   n_err = 0;

    alu #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .A          (a_in),
        .B          (b_in),
        .ALUControl (ctl),
        .ALUResult  (alu_result),
        .ALUFlags   (alu_flags),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Independent integer reference model.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int   ai;
        int   bi;
        int   r;
        logic c;
        exp_t e;
        ai = int'(a);
        bi = int'(b);
        r  = 0;
        c  = 1'b0;
        case (op)
            2'b00: begin r = ai + bi; c = (r > 15); r = r % 16; end
            2'b01: begin c = (ai < bi); r = (ai - bi + 16) % 16; end
            2'b10: r = ai & bi;
            default: begin
                if (bi < W) r = (ai << bi) % 16;
`ifdef ALU_SHIFT_CARRY_EN
                if (bi >= 1 && bi <= W) c = ((ai >> (W - bi)) & 1) == 1;
`endif
            end
        endcase
        e.res = r[W-1:0];
        e.c   = c;
        e.z   = (r == 0);
        return e;
    endfunction

    // Compare the DUT outputs against the scoreboard head, or against the held value if empty.
    task automatic check_cycle(input string tag);
        exp_t e;
        if (sb.size() > 0) begin
            e        = sb.pop_front();
            last_exp = e;
            chk({tag, ".vld"}, 32'(out_valid), 32'd1);
            chk({tag, ".res"}, 32'(alu_result), 32'(e.res));
            chk({tag, ".c"},   32'(alu_flags[FLAG_C]), 32'(e.c));
            chk({tag, ".z"},   32'(alu_flags[FLAG_Z]), 32'(e.z));
        end else begin
            chk({tag, ".vld"},   32'(out_valid), 32'd0);
            chk({tag, ".hold"},  32'(alu_result), 32'(last_exp.res));
            chk({tag, ".flags"}, 32'(alu_flags), 32'({last_exp.z, last_exp.c}));
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, check just after the rising edge.
    task automatic step(input string tag, input bit v, input alu_op_e op,
                        input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        @(negedge clk);
        in_valid = v;
        ctl      = op;
        a_in     = a;
        b_in     = b;
        if (v) sb.push_back(e);
        @(posedge clk);
        #1;
        check_cycle(tag);
    endtask

    function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic z);
        exp_t e;
        e.res = r;
        e.c   = c;
        e.z   = z;
        return e;
    endfunction

    initial begin
        logic shl_c;
`ifdef ALU_SHIFT_CARRY_EN
        shl_c = 1'b1;
`else
        shl_c = 1'b0;
`endif
        // Reset state, before any clock edge.
        #1;
        check_cycle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, issued back to back.
        step("add_carry", 1, ALU_ADD, 4'b1010, 4'b1001, mk(4'b0011, 1'b1, 1'b0));
        step("add_plain", 1, ALU_ADD, 4'b1010, 4'b0001, mk(4'b1011, 1'b0, 1'b0));
        step("add_zero",  1, ALU_ADD, 4'b0000, 4'b0000, mk(4'b0000, 1'b0, 1'b1));
        step("sub_borrow",1, ALU_SUB, 4'b0000, 4'b1111, mk(4'b0001, 1'b1, 1'b0));
        step("sub_plain", 1, ALU_SUB, 4'b1100, 4'b0011, mk(4'b1001, 1'b0, 1'b0));
        step("sub_equal", 1, ALU_SUB, 4'b1101, 4'b1101, mk(4'b0000, 1'b0, 1'b1));
        step("shl_1",     1, ALU_SHL, 4'b0100, 4'b0001, mk(4'b1000, 1'b0, 1'b0));
        step("shl_2",     1, ALU_SHL, 4'b0100, 4'b0010, mk(4'b0000, shl_c, 1'b1));
        step("and",       1, ALU_AND, 4'b1100, 4'b1010, mk(4'b1000, 1'b0, 1'b0));
        step("shl_width", 1, ALU_SHL, 4'b1111, 4'b0100, mk(4'b0000, shl_c, 1'b1));
        step("shl_big",   1, ALU_SHL, 4'b1111, 4'b1001, mk(4'b0000, 1'b0, 1'b1));
        step("add_last",  1, ALU_ADD, 4'b0111, 4'b0110, mk(4'b1101, 1'b0, 1'b0));

        // Idle cycle with junk on the operands: result holds, out_valid drops.
        step("idle", 0, ALU_SUB, 4'b0001, 4'b0010, '0);

        // Reset asserted between edges after a valid result: outputs clear at once.
        step("pre_rst", 1, ALU_AND, 4'b1111, 4'b0110, mk(4'b0110, 1'b0, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async.vld",   32'(out_valid), 32'd0);
        chk("rst_async.res",   32'(alu_result), 32'd0);
        chk("rst_async.flags", 32'(alu_flags), 32'd0);
        last_exp = '0;

        // An operation presented while in reset is dropped.
        @(negedge clk);
        in_valid = 1'b1;
        ctl      = ALU_ADD;
        a_in     = 4'b0011;
        b_in     = 4'b0100;
        @(posedge clk);
        #1;
        check_cycle("in_rst");
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_cycle("post_rst");

        step("first_after_rst", 1, ALU_SUB, 4'b0101, 4'b0011, mk(4'b0010, 1'b0, 1'b0));

        // Random back-to-back traffic against the model, with occasional idle cycles.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]   rop;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            bit           rv;
            rop = 2'($urandom_range(0, 3));
            ra  = W'($urandom_range(0, 15));
            rb  = W'($urandom_range(0, 15));
            rv  = ($urandom_range(0, 4) != 0);
            step("rand", rv, alu_op_e'(rop), ra, rb, model(rop, ra, rb));
        end

        step("drain", 0, ALU_ADD, '0, '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_alu
